ready_bits_collector: RTL and testbench

//  Per-wavefront ready-bit store and read-back. Issue-side producers post ready

---
 rtl/ready_bits_collector.sv | 116 +++++++++++
 tb/tb_ready_bits_collector.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ready_bits_collector.sv
// Per-wavefront ready-bit store: one entry per WF slot, set/clear merge per
// cycle, write-through registered read-back and a registered per-WF "any bit set"
// summary vector.

// One WF slot: merge of clear-then-set into the stored bits, plus its OR-reduce.
module ready_bits_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set_hit,
  input  logic         clr_hit,
  input  logic [W-1:0] set_bits,
  input  logic [W-1:0] clr_mask,
  output logic [W-1:0] entry_d,
  output logic [W-1:0] entry_q,
  output logic         any_q
);
  logic any_d;

  // Clear is applied first so a same-cycle set of the same bit wins.
  always_comb begin
    entry_d = (entry_q & ~(clr_hit ? clr_mask : '0)) | (set_hit ? set_bits : '0);
    any_d   = |entry_d;
  end

  // Entry and summary flops; summary tracks the entry as it stands after this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_q <= '0;
      any_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      any_q   <= any_d;
    end
  end
endmodule

module ready_bits_collector #(
  parameter int TOTAL_INFO_LENGTH = 8,
  parameter int WF_PER_CU         = 40,
  parameter int WF_ID_LENGTH      = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_en,
  input  logic [WF_ID_LENGTH-1:0]      set_wfid,
  input  logic [TOTAL_INFO_LENGTH-1:0] set_bits,
  input  logic                         clr_en,
  input  logic [WF_ID_LENGTH-1:0]      clr_wfid,
  input  logic [TOTAL_INFO_LENGTH-1:0] clr_mask,
  input  logic                         rd_req,
  input  logic [WF_ID_LENGTH-1:0]      rd_wfid,
  output logic                         rd_valid,
  output logic [TOTAL_INFO_LENGTH-1:0] rd_data,
  output logic                         rd_err,
  output logic [WF_PER_CU-1:0]         wf_any
);
  localparam int TIL = TOTAL_INFO_LENGTH;
  localparam int IDW = WF_ID_LENGTH;

  logic [WF_PER_CU-1:0]          set_hit, clr_hit;
  logic [WF_PER_CU-1:0][TIL-1:0] entries_d, entries_q;

  logic           rd_oob;
  logic [TIL-1:0] rd_sel;
  logic           rd_valid_d, rd_valid_q;
  logic           rd_err_d, rd_err_q;
  logic [TIL-1:0] rd_data_d, rd_data_q;

  // Out-of-range ids never decode to a slot, so those updates drop naturally.
  for (genvar g = 0; g < WF_PER_CU; g++) begin : g_wf
    assign set_hit[g] = set_en && (set_wfid == IDW'(g));
    assign clr_hit[g] = clr_en && (clr_wfid == IDW'(g));

    ready_bits_entry #(.W(TIL)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .set_hit  (set_hit[g]),
      .clr_hit  (clr_hit[g]),
      .set_bits (set_bits),
      .clr_mask (clr_mask),
      .entry_d  (entries_d[g]),
      .entry_q  (entries_q[g]),
      .any_q    (wf_any[g])
    );
  end

  // Read mux taps the post-update value so same-cycle set/clear is visible.
  always_comb begin
    rd_oob = ({1'b0, rd_wfid} >= (IDW+1)'(WF_PER_CU));
    rd_sel = '0;
    for (int e = 0; e < WF_PER_CU; e++)
      if (rd_wfid == IDW'(e)) rd_sel = entries_d[e];
    rd_valid_d = rd_req;
    rd_err_d   = rd_req ? rd_oob : rd_err_q;
    rd_data_d  = rd_req ? (rd_oob ? '0 : rd_sel) : rd_data_q;
  end

  // Read response register; data/err hold between requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_ready_bits_collector.sv
// Scoreboard bench for ready_bits_collector: a reference model of the entry
// array predicts each read response when the request is driven; responses are
// popped and compared after the clock edge.
module tb_ready_bits_collector;
  localparam int TIL = 8;
  localparam int WF  = 40;
  localparam int IDW = 6;

  typedef struct packed {
    logic           err;
    logic [TIL-1:0] data;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           set_en, clr_en, rd_req;
  logic [IDW-1:0] set_wfid, clr_wfid, rd_wfid;
  logic [TIL-1:0] set_bits, clr_mask;
  logic           rd_valid, rd_err;
  logic [TIL-1:0] rd_data;
  logic [WF-1:0]  wf_any;

  ready_bits_collector #(.TOTAL_INFO_LENGTH(TIL), .WF_PER_CU(WF), .WF_ID_LENGTH(IDW)) dut (
    .clk(clk), .rst(rst),
    .set_en(set_en), .set_wfid(set_wfid), .set_bits(set_bits),
    .clr_en(clr_en), .clr_wfid(clr_wfid), .clr_mask(clr_mask),
    .rd_req(rd_req), .rd_wfid(rd_wfid),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .wf_any(wf_any)
  );

  always #5 clk = ~clk;

  logic [TIL-1:0] mdl [WF];
  rsp_t           sb_q[$];
  rsp_t           last_rsp;
  logic           exp_valid;
  int             n_vec = 0;
  int             n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    set_en = 0; clr_en = 0; rd_req = 0;
    set_wfid = '0; clr_wfid = '0; rd_wfid = '0;
    set_bits = '0; clr_mask = '0;
  endtask

  // Predict the edge from the currently driven inputs, clock it, then check.
  task automatic cyc();
    logic [TIL-1:0] nxt [WF];
    logic [WF-1:0]  exp_any;
    rsp_t           r;
    if (!rst) begin
      for (int e = 0; e < WF; e++) mdl[e] = '0;
      sb_q.delete();
      last_rsp  = '0;
      exp_valid = 1'b0;
    end else begin
      for (int e = 0; e < WF; e++) begin
        nxt[e] = mdl[e];
        if (clr_en && int'(clr_wfid) == e) nxt[e] = nxt[e] & ~clr_mask;
        if (set_en && int'(set_wfid) == e) nxt[e] = nxt[e] | set_bits;
      end
      for (int e = 0; e < WF; e++) mdl[e] = nxt[e];
      exp_valid = rd_req;
      if (rd_req) begin
        r.err  = (int'(rd_wfid) >= WF);
        r.data = r.err ? '0 : mdl[rd_wfid];
        sb_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 64'(rd_valid), 64'(exp_valid));
    if (rd_valid) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else begin
        r = sb_q.pop_front();
        last_rsp = r;
      end
    end
    chk("rd_data", 64'(rd_data), 64'(last_rsp.data));
    chk("rd_err", 64'(rd_err), 64'(last_rsp.err));
    for (int e = 0; e < WF; e++) exp_any[e] = |mdl[e];
    chk("wf_any", 64'(wf_any), 64'(exp_any));
  endtask

  initial begin
    for (int e = 0; e < WF; e++) mdl[e] = '0;
    last_rsp = '0; exp_valid = 0;
    idle_inputs();

    // 1: reset held two cycles with a live set
    rst = 0; set_en = 1; set_wfid = 6'd5; set_bits = 8'hff;
    rd_req = 1; rd_wfid = 6'd5;
    cyc(); cyc();
    rst = 1; idle_inputs();
    cyc();

    // 2: set then read wf 5
    set_en = 1; set_wfid = 6'd5; set_bits = 8'h03;
    cyc();
    idle_inputs(); rd_req = 1; rd_wfid = 6'd5;
    cyc();
    idle_inputs();
    cyc();

    // 3: set + clear + read same wf, same bit
    set_en = 1; set_wfid = 6'd7; set_bits = 8'h01;
    clr_en = 1; clr_wfid = 6'd7; clr_mask = 8'h01;
    rd_req = 1; rd_wfid = 6'd7;
    cyc();
    idle_inputs();

    // 4: set wf 39 and clear wf 0 together
    set_en = 1; set_wfid = 6'd0; set_bits = 8'hf0;
    cyc();
    set_en = 1; set_wfid = 6'd39; set_bits = 8'h5a;
    clr_en = 1; clr_wfid = 6'd0; clr_mask = 8'hff;
    cyc();
    idle_inputs(); rd_req = 1; rd_wfid = 6'd39;
    cyc();
    rd_wfid = 6'd0;
    cyc();

    // 5: out-of-range read and set
    idle_inputs(); rd_req = 1; rd_wfid = 6'd40;
    set_en = 1; set_wfid = 6'd63; set_bits = 8'hff;
    clr_en = 1; clr_wfid = 6'd41; clr_mask = 8'hff;
    cyc();
    idle_inputs(); rd_req = 1; rd_wfid = 6'd63;
    cyc();
    idle_inputs();
    cyc();

    // 6: back-to-back reads, then reset mid-stream
    for (int i = 1; i <= 3; i++) begin
      set_en = 1; set_wfid = IDW'(i); set_bits = TIL'(8'h10 << i);
      cyc();
    end
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      rd_req = 1; rd_wfid = IDW'(i);
      cyc();
    end
    rst = 0; rd_req = 1; rd_wfid = 6'd2; set_en = 1; set_wfid = 6'd2; set_bits = 8'hff;
    cyc();
    rst = 1; idle_inputs();
    cyc();

    // random traffic, ids span the full 6-bit range
    for (int i = 0; i < 300; i++) begin
      set_en   = ($urandom_range(0, 1) == 1);
      set_wfid = IDW'($urandom_range(0, 63));
      set_bits = TIL'($urandom);
      clr_en   = ($urandom_range(0, 1) == 1);
      clr_wfid = ($urandom_range(0, 2) == 0) ? set_wfid : IDW'($urandom_range(0, 63));
      clr_mask = TIL'($urandom);
      rd_req   = ($urandom_range(0, 2) != 0);
      rd_wfid  = ($urandom_range(0, 1) == 1) ? set_wfid : IDW'($urandom_range(0, 63));
      cyc();
    end
    idle_inputs();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
